alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//   Shares the single combinational ALU between NUM_REQ requesters (e.g. issue
//   stage, address generation, branch-target unit). Round-robin arbitration
//   uses valid/ready request channels and one registered response slot with
//   backpressure. An optional lock holds the grant for multi-op sequences.
//   Sits between the requesters and the alu instance; drives its a/b/alu_op.
// PARAMETERS
//   DATA_WIDTH  32  operand/result width; must match the alu instance
//   NUM_REQ     4   number of requesters, 2..8
//   ID_W        $clog2(NUM_REQ)  response id width (derived, min 1)
// PORTS
//   clk         in   1                    rising-edge clock
//   rst         in   1                    synchronous active-high reset
//   req_valid   in   NUM_REQ              per-requester op valid
//   req_ready   out  NUM_REQ              per-requester grant/accept (comb)
//   req_a       in   NUM_REQ*DATA_WIDTH   operand a, slice i = requester i
//   req_b       in   NUM_REQ*DATA_WIDTH   operand b, slice i = requester i
//   req_op      in   NUM_REQ*3            alu_op code, slice i = requester i
//   req_lock    in   NUM_REQ              keep grant after this op (sampled on accept)
//   alu_a       out  DATA_WIDTH           to alu.a
//   alu_b       out  DATA_WIDTH           to alu.b
//   alu_op      out  3                    to alu.alu_op
//   alu_result  in   DATA_WIDTH           from alu.result
//   alu_zero    in   1                    from alu.zero
//   rsp_valid   out  1                    response slot holds a result
//   rsp_ready   in   1                    consumer takes response
//   rsp_data    out  DATA_WIDTH           registered alu_result
//   rsp_zero    out  1                    registered alu_zero
//   rsp_id      out  ID_W                 index of the requester that issued the op
// BEHAVIOUR
//   - Reset: rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_id=0, rr pointer=0,
//     FSM=ARB, lock owner=0. While rst=1: req_ready=0, alu_a/alu_b/alu_op=0.
//   - slot_free = !rsp_valid || rsp_ready. No grant when !slot_free.
//   - FSM ARB: grant the first valid requester scanning from ptr up to
//     NUM_REQ-1, then wrapping from 0. One-hot req_ready. On accept of i:
//     ptr <= (i+1) mod NUM_REQ; if req_lock[i], owner<=i and FSM->LOCKED.
//   - FSM LOCKED: only owner may be granted; other valids wait. On accept
//     with req_lock[owner]=0, FSM->ARB, ptr <= owner+1 mod NUM_REQ. The
//     owner may drop req_valid indefinitely; the lock persists (no timeout).
//   - ALU drive: granted slice is muxed onto alu_a/alu_b/alu_op in the
//     accept cycle; with no grant all three are 0.
//   - Accept = req_valid[i] && req_ready[i]. On the next edge: rsp_valid<=1,
//     rsp_data<=alu_result, rsp_zero<=alu_zero, rsp_id<=i. Latency is 1 cycle.
//   - Simultaneous drain+accept (rsp_valid && rsp_ready && accept): slot is
//     refilled and rsp_valid stays 1. Full throughput is 1 op/cycle.
//   - Drain only: rsp_valid<=0; rsp_data/rsp_zero/rsp_id hold last value.
//   - Backpressure: rsp_valid && !rsp_ready -> every rsp_* output is held
//     stable and req_ready=0.
//   - Requesters must hold req_* stable while valid and not ready; the
//     arbiter does not buffer operands.
//   - Reset mid-operation: the pending response is dropped and the lock is
//     released, with all reset values applied.
//   - Unsupported op codes pass through unchanged; the ALU returns 0 with zero=1.
// TESTING (NUM_REQ=4, DATA_WIDTH=32)
//   1. rst=1 for 2 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0;
//      first grant after reset goes to requester 0.
//   2. req2 only: a=5, b=7, op=ALU_ADD, rsp_ready=1 -> next cycle rsp_valid=1,
//      rsp_data=12, rsp_zero=0, rsp_id=2.
//   3. All 4 valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,
//      one accept per cycle, rsp_id follows one cycle later.
//   4. Slot full with rsp_ready=0 for 3 cycles -> req_ready=0 and rsp_* stable;
//      raising rsp_ready accepts the next request in that same cycle.
//   5. req1 with lock=1 for 3 ops, req0/req2 also valid -> grants 1,1,1,
//      then req1 lock=0 op granted, then 2, then 0; rst during LOCKED
//      releases the lock.
//   6. a=32'hFFFF_FFFF, b=1, ALU_ADD -> rsp_data=0, rsp_zero=1.
//      Unsupported op 3'b111 -> rsp_data=0, rsp_zero=1.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters,
// with an optional grant lock and a single registered response slot.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]          req_op,
  input  logic [NUM_REQ-1:0]            req_lock,
  output logic [DATA_WIDTH-1:0]         alu_a,
  output logic [DATA_WIDTH-1:0]         alu_b,
  output logic [2:0]                    alu_op,
  input  logic [DATA_WIDTH-1:0]         alu_result,
  input  logic                          alu_zero,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_zero,
  output logic [ID_W-1:0]               rsp_id
);

  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [ID_W-1:0]       owner_q, owner_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_zero_q, rsp_zero_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;

  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       gnt_idx;
  logic [ID_W-1:0]       gnt_next;
  logic                  accept;
  logic                  slot_free;
  logic                  found;

  always_comb begin
    int unsigned sum;
    sum       = 0;
    slot_free = !rsp_valid_q || rsp_ready;
    grant     = '0;
    gnt_idx   = '0;
    found     = 1'b0;
    if (!rst && slot_free) begin
      if (state_q == ST_LOCKED) begin
        if (req_valid[owner_q]) begin
          grant[owner_q] = 1'b1;
          gnt_idx        = owner_q;
        end
      end else begin
        // Scan ptr..NUM_REQ-1 then wrap to 0; the first valid wins.
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
          sum = 32'(ptr_q) + k;
          if (sum >= unsigned'(NUM_REQ)) sum = sum - unsigned'(NUM_REQ);
          if (!found && req_valid[ID_W'(sum)]) begin
            found                = 1'b1;
            grant[ID_W'(sum)]    = 1'b1;
            gnt_idx              = ID_W'(sum);
          end
        end
      end
    end
    accept   = |grant;
    gnt_next = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        alu_a  = req_a[k*DATA_WIDTH +: DATA_WIDTH];
        alu_b  = req_b[k*DATA_WIDTH +: DATA_WIDTH];
        alu_op = req_op[k*3 +: 3];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_id_d    = rsp_id_q;
    if (accept) begin
      ptr_d       = gnt_next;
      rsp_valid_d = 1'b1;
      rsp_data_d  = alu_result;
      rsp_zero_d  = alu_zero;
      rsp_id_d    = gnt_idx;
      if (state_q == ST_ARB && req_lock[gnt_idx]) begin
        state_d = ST_LOCKED;
        owner_d = gnt_idx;
      end else if (state_q == ST_LOCKED && !req_lock[gnt_idx]) begin
        state_d = ST_ARB;
      end
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ARB;
      ptr_q       <= '0;
      owner_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-free behavioural model.
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*DW-1:0] req_a;
  logic [NR*DW-1:0] req_b;
  logic [NR*3-1:0] req_op;
  logic [NR-1:0]   req_lock;
  logic [DW-1:0]   alu_a;
  logic [DW-1:0]   alu_b;
  logic [2:0]      alu_op;
  logic [DW-1:0]   alu_result;
  logic            alu_zero;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic            rsp_zero;
  logic [IW-1:0]   rsp_id;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_lock(req_lock),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  // Reference ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 unsupported.
  function automatic logic [DW:0] ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [2:0] op);
    logic [DW-1:0] r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[4:0];
      3'd6: r = a >> b[4:0];
      default: r = '0;
    endcase
    return {(r == '0), r};
  endfunction

  always_comb begin
    logic [DW:0] t;
    t = ref_alu(alu_a, alu_b, alu_op);
    alu_result = t[DW-1:0];
    alu_zero   = t[DW];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model state
  bit          m_init   = 0;
  bit          m_locked = 0;
  int          m_owner  = 0;
  int          m_ptr    = 0;
  bit          m_rv     = 0;
  logic [DW-1:0] m_rd   = '0;
  bit          m_rz     = 0;
  int          m_rid    = 0;
  int          cur_pick = -1;
  logic [NR-1:0] acc_mask = '0;

  function automatic int model_pick();
    if (rst || !(!m_rv || rsp_ready)) return -1;
    if (m_locked) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < NR; k++) begin
      if (req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [NR-1:0] exp_ready;
    logic [DW-1:0] ea, eb;
    logic [2:0]    eo;
    cur_pick = model_pick();
    acc_mask = req_valid & req_ready;
    if (m_init) begin
      exp_ready = '0;
      ea = '0; eb = '0; eo = '0;
      if (cur_pick >= 0) begin
        exp_ready = NR'(1 << cur_pick);
        ea = req_a[cur_pick*DW +: DW];
        eb = req_b[cur_pick*DW +: DW];
        eo = req_op[cur_pick*3 +: 3];
      end
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("alu_a", 64'(alu_a), 64'(ea));
      chk("alu_b", 64'(alu_b), 64'(eb));
      chk("alu_op", 64'(alu_op), 64'(eo));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
      chk("rsp_data", 64'(rsp_data), 64'(m_rd));
      chk("rsp_zero", 64'(rsp_zero), 64'(m_rz));
      chk("rsp_id", 64'(rsp_id), 64'(m_rid));
    end
  end

  always @(posedge clk) begin
    logic [DW:0] t;
    if (rst) begin
      m_init = 1; m_locked = 0; m_owner = 0; m_ptr = 0;
      m_rv = 0; m_rd = '0; m_rz = 0; m_rid = 0;
    end else if (m_init && cur_pick >= 0) begin
      t = ref_alu(req_a[cur_pick*DW +: DW], req_b[cur_pick*DW +: DW], req_op[cur_pick*3 +: 3]);
      m_rv = 1; m_rd = t[DW-1:0]; m_rz = t[DW]; m_rid = cur_pick;
      m_ptr = (cur_pick + 1) % NR;
      if (!m_locked && req_lock[cur_pick]) begin
        m_locked = 1; m_owner = cur_pick;
      end else if (m_locked && !req_lock[cur_pick]) begin
        m_locked = 0;
      end
    end else if (rsp_ready) begin
      m_rv = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [2:0] op, input logic lk);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    req_op[i*3 +: 3]  = op;
    req_lock[i]       = lk;
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b1;
    req_valid = 4'hF; req_a = '0; req_b = '0; req_op = '0; req_lock = '0;
    for (int i = 0; i < NR; i++) set_req(i, 32'(i + 100), 32'd1, 3'd0, 1'b0);

    // Reset with all requesters valid
    for (int c = 0; c < 2; c++) begin
      tick(); #2;
      chk("t1_rst_ready", 64'(req_ready), 64'h0);
      chk("t1_rst_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("t1_rst_alu_a", 64'(alu_a), 64'h0);
    end
    tick();
    rst = 1'b0;
    #2 chk("t1_first_grant", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    #2 chk("t1_rsp_id", 64'(rsp_id), 64'h0);

    // Single op from requester 2
    set_req(2, 32'd5, 32'd7, 3'd0, 1'b0);
    req_valid = 4'b0100;
    #1 chk("t2_ready", 64'(req_ready), 64'h4);
    tick();
    req_valid = '0;
    #2;
    chk("t2_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("t2_rsp_data", 64'(rsp_data), 64'd12);
    chk("t2_rsp_zero", 64'(rsp_zero), 64'h0);
    chk("t2_rsp_id", 64'(rsp_id), 64'h2);

    // Bring pointer to 0 via requester 3, then all four valid
    req_valid = 4'b1000;
    #1 chk("t3_pre_ready", 64'(req_ready), 64'h8);
    tick();
    for (int i = 0; i < NR; i++) set_req(i, 32'(10 * i + 1), 32'd2, 3'd0, 1'b0);
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #2 chk("t3_rr_ready", 64'(req_ready), 64'(1 << (k % 4)));
      if (k > 0) begin
        chk("t3_rr_id", 64'(rsp_id), 64'((k - 1) % 4));
        chk("t3_rr_data", 64'(rsp_data), 64'(10 * ((k - 1) % 4) + 3));
      end
      tick();
    end

    // Backpressure: slot full, consumer stalled
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("t4_bp_ready", 64'(req_ready), 64'h0);
      chk("t4_bp_valid", 64'(rsp_valid), 64'h1);
      chk("t4_bp_id", 64'(rsp_id), 64'h0);
      chk("t4_bp_data", 64'(rsp_data), 64'd3);
      tick();
    end
    rsp_ready = 1'b1;
    #2 chk("t4_release_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    #2 chk("t4_release_id", 64'(rsp_id), 64'h1);

    // Lock sequence
    req_valid = 4'b0001;
    #1 chk("t5_pre_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'b0111;
    for (int k = 0; k < 4; k++) begin
      req_lock[1] = (k < 3);
      #2 chk("t5_lock_ready", 64'(req_ready), 64'h2);
      tick();
    end
    req_valid = 4'b0101; req_lock = '0;
    #2 chk("t5_after_unlock", 64'(req_ready), 64'h4);
    tick();
    req_valid = 4'b0001;
    #2 chk("t5_then_0", 64'(req_ready), 64'h1);
    tick();

    // Reset while locked releases the lock
    req_valid = 4'b0010; req_lock[1] = 1'b1;
    #2 chk("t5_lock2_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = 4'b0001; req_lock = '0;
    for (int c = 0; c < 2; c++) begin
      #2 chk("t5_locked_wait", 64'(req_ready), 64'h0);
      tick();
    end
    rst = 1'b1;
    #2 chk("t5_rst_ready", 64'(req_ready), 64'h0);
    tick();
    rst = 1'b0;
    #2;
    chk("t5_post_rst_valid", 64'(rsp_valid), 64'h0);
    chk("t5_post_rst_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;

    // Overflow to zero, then unsupported op
    set_req(3, 32'hFFFF_FFFF, 32'd1, 3'd0, 1'b0);
    req_valid = 4'b1000;
    #2 chk("t6_ready", 64'(req_ready), 64'h8);
    tick();
    #2;
    chk("t6_ovf_data", 64'(rsp_data), 64'h0);
    chk("t6_ovf_zero", 64'(rsp_zero), 64'h1);
    set_req(3, 32'd123, 32'd45, 3'd7, 1'b0);
    #1 chk("t6_bad_op_alu_op", 64'(alu_op), 64'h7);
    tick();
    req_valid = '0;
    #2;
    chk("t6_badop_data", 64'(rsp_data), 64'h0);
    chk("t6_badop_zero", 64'(rsp_zero), 64'h1);
    chk("t6_badop_id", 64'(rsp_id), 64'h3);

    // Randomized traffic; requesters hold their op until it is accepted
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 299) == 0);
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NR; i++) begin
        if (!(req_valid[i] && !acc_mask[i])) begin
          req_valid[i] = ($urandom_range(0, 9) < 6);
          set_req(i,
                  ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom),
                  ($urandom_range(0, 7) == 0) ? 32'd1 : 32'($urandom),
                  3'($urandom_range(0, 7)),
                  ($urandom_range(0, 4) == 0));
        end
      end
      tick();
    end

    rst = 1'b0; req_valid = '0;
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
